// File: rtl/pwl_coef_loader.sv
// -----------------------------------------------------------------------------
// pwl_coef_loader
// Loads a piecewise-linear coefficient table of DEPTH = 2^U words from a
// valid/ready stream. Every accepted beat {k, b} is written to the table one
// cycle later at the next sequential address, and a running XOR checksum is
// kept. A load is good only if s_last arrives exactly on beat DEPTH-1. An early
// or missing s_last leaves the block in a sticky error state until the next
// start.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      one-cycle request to begin a load (honoured in IDLE/ERR only)
//   s_valid    stream beat valid
//   s_ready    stream ready; high only while loading
//   s_data     stream word {k, b}, k in the MSBs
//   s_last     final beat marker
//   wr_en      table write strobe (one cycle after each handshake)
//   wr_addr    table write address
//   wr_data    table write word
//   busy       load in progress
//   done       one-cycle pulse after a successful final beat
//   err        sticky framing error
//   tbl_valid  table holds a complete, error-free load
//   checksum   XOR of all words accepted in the current or last load
// -----------------------------------------------------------------------------
module pwl_coef_loader #(
   parameter int U       = 8,
   parameter int K_WIDTH = 16,
   parameter int B_WIDTH = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic                       s_valid,
   output logic                       s_ready,
   input  logic [K_WIDTH+B_WIDTH-1:0] s_data,
   input  logic                       s_last,
   output logic                       wr_en,
   output logic [U-1:0]               wr_addr,
   output logic [K_WIDTH+B_WIDTH-1:0] wr_data,
   output logic                       busy,
   output logic                       done,
   output logic                       err,
   output logic                       tbl_valid,
   output logic [K_WIDTH+B_WIDTH-1:0] checksum
);

   localparam int W = K_WIDTH + B_WIDTH;

   // Address of the final table entry; beats beyond it can never be accepted.
   localparam logic [U-1:0] LAST_ADDR = {U{1'b1}};
   localparam logic [U-1:0] CNT_ONE   = {{(U-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2,
      ST_ERR  = 2'd3
   } state_t;

   state_t         state_r;
   logic [U-1:0]   count_r;
   logic           wr_en_r;
   logic [U-1:0]   wr_addr_r;
   logic [W-1:0]   wr_data_r;
   logic           done_r;
   logic           err_r;
   logic           tbl_valid_r;
   logic [W-1:0]   checksum_r;
   logic           accept_s;
   logic           at_top_s;

   // Running checksum step: fold one accepted word into the accumulator.
   function automatic logic [W-1:0] fold_word(input logic [W-1:0] acc,
                                              input logic [W-1:0] word);
      return acc ^ word;
   endfunction

   // Ready is a pure decode of the state register, so it needs no pipeline.
   assign s_ready  = (state_r == ST_LOAD);
   assign accept_s = s_valid & s_ready;
   assign at_top_s = (count_r == LAST_ADDR);

   assign wr_en     = wr_en_r;
   assign wr_addr   = wr_addr_r;
   assign wr_data   = wr_data_r;
   assign busy      = (state_r == ST_LOAD);
   assign done      = done_r;
   assign err       = err_r;
   assign tbl_valid = tbl_valid_r;
   assign checksum  = checksum_r;

   // Load FSM together with its registered write port and status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         count_r     <= '0;
         wr_en_r     <= 1'b0;
         wr_addr_r   <= '0;
         wr_data_r   <= '0;
         done_r      <= 1'b0;
         err_r       <= 1'b0;
         tbl_valid_r <= 1'b0;
         checksum_r  <= '0;
      end else begin
         // Strobes default low; they are raised only for the single cycle needed.
         wr_en_r <= 1'b0;
         done_r  <= 1'b0;
         case (state_r)
            ST_IDLE, ST_ERR: begin
               if (start) begin
                  state_r     <= ST_LOAD;
                  count_r     <= '0;
                  checksum_r  <= '0;
                  err_r       <= 1'b0;
                  tbl_valid_r <= 1'b0;
               end else begin
                  state_r <= state_r;
               end
            end
            ST_LOAD: begin
               if (accept_s) begin
                  // The beat is written even when it turns out to be a framing error.
                  wr_en_r    <= 1'b1;
                  wr_addr_r  <= count_r;
                  wr_data_r  <= s_data;
                  checksum_r <= fold_word(checksum_r, s_data);
                  if (s_last && at_top_s) begin
                     state_r <= ST_DONE;
                     done_r  <= 1'b1;
                  end else if (s_last || at_top_s) begin
                     // Early last, or the table is full without a last marker.
                     state_r <= ST_ERR;
                     err_r   <= 1'b1;
                  end else begin
                     // Counter only advances below the top, so it never wraps.
                     count_r <= count_r + CNT_ONE;
                  end
               end else begin
                  state_r <= ST_LOAD;
               end
            end
            ST_DONE: begin
               state_r     <= ST_IDLE;
               tbl_valid_r <= 1'b1;
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/pwl_coef_loader.md
PWL_COEF_LOADER -- requirements
Module: pwl_coef_loader

Interface
REQ-001 SHALL have parameter U, default 8, meaning address width; table depth DEPTH = 2^U entries.
REQ-002 SHALL have parameter K_WIDTH, default 16, meaning signed slope field width (Q4.12).
REQ-003 SHALL have parameter B_WIDTH, default 16, meaning signed intercept field width (Q4.12).
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst_n, input, 1, meaning reset, asynchronous and active-low.
REQ-006 SHALL have port start, input, 1, meaning a one-cycle request to begin a table load.
REQ-007 SHALL have port s_valid, input, 1, meaning the coefficient stream beat is valid.
REQ-008 SHALL have port s_ready, output, 1, meaning the block accepts a beat this cycle.
REQ-009 SHALL have port s_data, input, K_WIDTH+B_WIDTH, meaning {k, b}, with k in the MSBs.
REQ-010 SHALL have port s_last, input, 1, meaning the final beat of the load.
REQ-011 SHALL have port wr_en, output, 1, meaning the coefficient-table write strobe.
REQ-012 SHALL have port wr_addr, output, U, meaning the table write address.
REQ-013 SHALL have port wr_data, output, K_WIDTH+B_WIDTH, meaning the table write word, {k, b} unchanged.
REQ-014 SHALL have port busy, output, 1, meaning the block is in state LOAD.
REQ-015 SHALL have port done, output, 1, meaning a one-cycle pulse on a successful load.
REQ-016 SHALL have port err, output, 1, meaning a sticky framing error.
REQ-017 SHALL have port tbl_valid, output, 1, meaning the table holds a complete, error-free load.
REQ-018 SHALL have port checksum, output, K_WIDTH+B_WIDTH, meaning the XOR of all accepted words of the current or last load.

Function
REQ-019 SHALL implement the states IDLE, LOAD, DONE and ERR.
REQ-020 SHALL transition from IDLE or ERR to LOAD on start=1, and in the same step clear the beat counter, checksum, err and tbl_valid.
REQ-021 SHALL ignore start while in LOAD or DONE.
REQ-022 SHALL assert s_ready combinationally only in LOAD; s_ready=0 in every other state.
REQ-023 SHALL count a beat as accepted only when s_valid=1 and s_ready=1 in the same cycle; with s_valid=0 the state holds indefinitely.
REQ-024 SHALL, for each accepted beat, drive wr_en=1 with wr_addr=counter and wr_data=s_data exactly one cycle later; the counter increments by 1 per accepted beat.
REQ-025 SHALL update checksum to checksum XOR s_data on the cycle after each accepted beat.
REQ-026 SHALL go LOAD->DONE when an accepted beat has s_last=1 and counter=DEPTH-1; DONE lasts one cycle with done=1, then returns to IDLE with tbl_valid=1.
REQ-027 SHALL go LOAD->ERR when an accepted beat has s_last=1 and counter<DEPTH-1 (early last), or has s_last=0 and counter=DEPTH-1 (missing last); err=1 from the next cycle.
REQ-028 SHALL still write the erroring beat to the table (wr_en pulse per REQ-024), and SHALL accept no further beats in ERR.
REQ-029 SHALL hold err=1 and tbl_valid=0 in ERR until the next start.
REQ-030 SHALL never let the counter wrap; a DEPTH-th beat is impossible because of REQ-027.
REQ-031 SHALL have a latency of 1 cycle from handshake to wr_en, and 1 cycle from the final handshake to done.

Reset
REQ-032 SHALL, while rst_n=0 (asynchronously), enter IDLE and set s_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, err=0, tbl_valid=0, checksum=0 and counter=0.
REQ-033 SHALL, on reset asserted mid-LOAD, abandon the load; the pending wr_en is not issued and tbl_valid stays 0 after release.

Verification
REQ-034 SHALL cover a full load: start, then 256 beats with data = {addr, ~addr} and s_last on beat 255 -> 256 wr_en pulses, addresses 0..255 in order, done pulse 1 cycle after the last handshake, tbl_valid=1, checksum = XOR of all words.
REQ-035 SHALL cover backpressure gaps: s_valid toggled randomly during a full load -> identical writes and checksum to REQ-034, and no wr_en in cycles without a handshake.
REQ-036 SHALL cover early last: s_last on beat 10 -> 11 writes (addresses 0..10), err=1, s_ready=0 thereafter, tbl_valid=0.
REQ-037 SHALL cover missing last: 256 beats with s_last=0 throughout -> ERR after beat 255, err=1, and a 257th s_valid is not accepted.
REQ-038 SHALL cover recovery: start in ERR, then a good load -> err clears on the start cycle, then done=1 and tbl_valid=1.
REQ-039 SHALL cover reset mid-load: rst_n=0 after beat 100 -> all outputs 0 immediately, state IDLE, and no further wr_en until a new start.
